fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the branch predictor.
- Owns the PC register and a single-outstanding request/response port to instruction memory.
- Presents the current IF pc/instruction to the predictor, takes the predictor's next-pc/flush back, and drives the IF/ID pipeline register.
- Handles ID stalls by holding the fetched instruction, and EX flushes by killing in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction inserted into IF/ID on bubbles (addi x0,x0,0).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_next_pc  in  32  next PC from predictor (predicted, or corrected when i_flush).
- i_flush  in  1  EX misprediction flush from predictor.
- i_stall  in  1  ID hazard stall; IF/ID must hold.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  fetch address (= pc).
- i_imem_ready  in  1  memory accepts request this cycle.
- i_imem_rvalid  in  1  read data valid (≥1 cycle after accept).
- i_imem_rdata  in  32  instruction word.
- o_IF_pc  out  32  pc of the instruction currently in IF (to predictor).
- o_IF_inst  out  32  instruction in IF (to predictor); NOP_INST when o_IF_valid=0.
- o_IF_valid  out  1  IF holds a valid instruction this cycle.
- o_ID_pc  out  32  IF/ID register pc.
- o_ID_pc_four  out  32  IF/ID pc+4.
- o_ID_inst  out  32  IF/ID instruction.
- o_ID_valid  out  1  IF/ID valid.

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- o_imem_req = (state==S_REQ).
- o_IF_valid = (S_WAIT & i_imem_rvalid) | S_HOLD.
- o_IF_inst = S_HOLD ? hold_inst : i_imem_rdata (NOP_INST if !o_IF_valid).
- o_IF_pc = pc in all states.
- Reset (sync, priority over all): pc=RESET_PC, state=S_REQ, hold_inst=NOP_INST; ID regs: valid=0, inst=NOP_INST, pc=0, pc_four=0.
- advance = o_IF_valid & ~i_stall & ~i_flush.
  - IF/ID <= {pc, pc+4 (mod 2^32), o_IF_inst, 1}; pc <= i_next_pc; state -> S_REQ.
  - New request issues the cycle after advance. Throughput with 1-cycle memory: one instruction every 2 cycles.
- Priority per cycle: i_rst > i_flush > i_stall > normal.
- Flush:
  - pc <= i_next_pc; IF/ID valid <= 0, inst <= NOP_INST (overrides i_stall); hold_inst discarded.
  - Next state is S_DRAIN if a request is outstanding whose data is not arriving this cycle: state S_WAIT & ~i_imem_rvalid, or S_REQ & i_imem_ready. Otherwise next state is S_REQ.
- Stall (no flush), IF/ID unchanged:
  - S_WAIT with rvalid: hold_inst <= i_imem_rdata, -> S_HOLD.
  - S_HOLD: stay.
  - S_REQ/S_WAIT without data: normal progress, no IF/ID write.
- No-stall, no-flush, !o_IF_valid: IF/ID <= bubble (valid 0, NOP_INST).
- Transitions:
  - S_REQ -> S_WAIT on i_imem_ready.
  - S_WAIT -> S_REQ on advance.
  - S_HOLD -> S_REQ on advance.
  - S_DRAIN: discard the first i_imem_rvalid, then -> S_REQ; flushes in S_DRAIN update pc only and stay in S_DRAIN.
- Exactly one outstanding request; o_imem_addr stable while o_imem_req & ~i_imem_ready (pc changes only on flush).
- i_next_pc is sampled only on advance or flush; ignored otherwise.
- Reset mid-fetch: the late rvalid after reset lands in S_REQ and is ignored (rvalid outside S_WAIT/S_DRAIN has no effect).

Decomposition:
- Shared package (pipeline types): fetch state enum; NOP_INST constant; if_id_t struct {pc, pc_four, inst, valid} reused by decode.
- One natural sub-module: if_id_reg (IF/ID register with stall-hold and flush-clear, synchronous active-high reset).
- FSM and PC stay in fetch_stage.

Test Plan:
- Reset then run: i_rst 1 cycle, memory ready=1, 1-cycle latency, i_next_pc=pc+4.
  - Required: first o_imem_addr=0x0, then 0x4, 0x8; o_ID_pc follows 0x0, 0x4, 0x8 with o_ID_valid=1 and o_ID_pc_four=pc+4.
- Stall while data returns: rvalid with inst 0x00500093 and i_stall=1 for 3 cycles.
  - Required: S_HOLD, o_IF_inst stays 0x00500093, IF/ID unchanged, no new request.
  - After release: IF/ID gets 0x00500093 and the next request address = i_next_pc.
- Flush during outstanding fetch: request 0x10 accepted, i_flush=1 with i_next_pc=0x40 before rvalid.
  - Required: o_ID_valid=0 with NOP_INST; the returning 0x10 data is discarded; next o_imem_addr=0x40.
- Flush and stall same cycle: i_stall=1, i_flush=1, i_next_pc=0x80.
  - Required: IF/ID cleared (valid 0) and the next request is 0x80.
- Backpressure: i_imem_ready=0 for 4 cycles.
  - Required: o_imem_req=1 with o_imem_addr constant; o_ID_valid=0 bubbles inserted.
- Predicted taken: predictor returns i_next_pc=0x200 for the instruction at 0x1C.
  - Required: after advance, o_imem_addr=0x200 and o_ID_pc=0x1C.

Source files
------------

// File: rtl/fetch_pkg.sv
// Pipeline types shared by the fetch stage and decode.
// Holds the fetch FSM encoding, the canonical NOP word and the IF/ID payload.
// No logic here; types and constants only.
package fetch_pkg;

    // addi x0, x0, 0 -- what IF/ID carries when there is no instruction
    localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request presented to imem, waiting for accept
        S_WAIT  = 2'd1,  // request accepted, waiting for read data
        S_HOLD  = 2'd2,  // data captured during an ID stall
        S_DRAIN = 2'd3   // killed fetch still in flight, its data is dropped
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_four;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with stall-hold and flush/bubble clear.
// Latency: one cycle from i_load/i_clear to o_dat.
// Backpressure: holds its contents whenever neither load nor clear is asserted.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  logic   i_clear,
    input  if_id_t i_dat,
    output if_id_t o_dat
);

    if_id_t r_dat;

    // Clear wins over load so a flush always empties the register; pc fields
    // are left alone on a clear since they are meaningless once valid drops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dat.pc      <= 32'h0;
            r_dat.pc_four <= 32'h0;
            r_dat.inst    <= NOP_INST;
            r_dat.valid   <= 1'b0;
        end else if (i_clear) begin
            r_dat.inst    <= NOP_INST;
            r_dat.valid   <= 1'b0;
        end else if (i_load) begin
            r_dat         <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, feeds IF/ID.
// Latency: accept -> data >= 1 cycle; advance writes IF/ID and reissues the next cycle.
// Backpressure: imem not ready holds addr; ID stall parks data in S_HOLD; flush kills in-flight data.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc,
    input  logic        i_flush,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_IF_pc,
    output logic [31:0] o_IF_inst,
    output logic        o_IF_valid,
    output logic [31:0] o_ID_pc,
    output logic [31:0] o_ID_pc_four,
    output logic [31:0] o_ID_inst,
    output logic        o_ID_valid
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_inst;

    logic         w_if_valid;
    logic [31:0]  w_if_inst;
    logic         w_advance;
    logic         w_id_load;
    logic         w_id_clear;
    if_id_t       w_id_next;
    if_id_t       w_id_cur;

    assign w_if_valid = ((r_state == S_WAIT) & i_imem_rvalid) | (r_state == S_HOLD);
    assign w_advance  = w_if_valid & ~i_stall & ~i_flush;
    assign w_id_load  = w_advance;
    // Flush clears even under stall; an unstalled cycle with nothing in IF inserts a bubble
    assign w_id_clear = i_flush | (~i_stall & ~w_if_valid);

    // IF instruction: parked word in S_HOLD, live memory data otherwise, NOP when empty
    always_comb begin
        w_if_inst = NOP_INST;
        if (r_state == S_HOLD) begin
            w_if_inst = r_hold_inst;
        end else if (w_if_valid) begin
            w_if_inst = i_imem_rdata;
        end
    end

    // Payload written into IF/ID when the instruction advances
    always_comb begin
        w_id_next.pc      = r_pc;
        w_id_next.pc_four = r_pc + 32'd4;
        w_id_next.inst    = w_if_inst;
        w_id_next.valid   = 1'b1;
    end

    // Fetch FSM and PC; priority is reset, flush, stall, then normal progress
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_state     <= S_REQ;
            r_hold_inst <= NOP_INST;
        end else if (i_flush) begin
            r_pc        <= i_next_pc;
            r_hold_inst <= NOP_INST;
            case (r_state)
                S_REQ:   r_state <= i_imem_ready  ? S_DRAIN : S_REQ;
                S_WAIT:  r_state <= i_imem_rvalid ? S_REQ   : S_DRAIN;
                // Already draining: keep waiting unless the stale data lands now
                S_DRAIN: r_state <= i_imem_rvalid ? S_REQ   : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (i_stall) begin
                            r_hold_inst <= i_imem_rdata;
                            r_state     <= S_HOLD;
                        end else begin
                            r_pc    <= i_next_pc;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        r_pc        <= i_next_pc;
                        r_hold_inst <= NOP_INST;
                        r_state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_id_load),
        .i_clear (w_id_clear),
        .i_dat   (w_id_next),
        .o_dat   (w_id_cur)
    );

    assign o_imem_req   = (r_state == S_REQ);
    assign o_imem_addr  = r_pc;
    assign o_IF_pc      = r_pc;
    assign o_IF_inst    = w_if_inst;
    assign o_IF_valid   = w_if_valid;
    assign o_ID_pc      = w_id_cur.pc;
    assign o_ID_pc_four = w_id_cur.pc_four;
    assign o_ID_inst    = w_id_cur.inst;
    assign o_ID_valid   = w_id_cur.valid;

endmodule
